// File: rtl/rs_alloc_issue_ctrl.sv
// rs_alloc_issue_ctrl: reservation-station allocate/issue controller.
// Tracks entry occupancy and the relative age of entries, grants up to
// ALLOC_W allocations per cycle to the lowest free slots, and issues up
// to ISSUE_W ready entries per cycle, oldest first, via registered outputs.
// Optional feature macro: RS_OCC_STATS_EN adds occupancy count/peak ports.
module rs_alloc_issue_ctrl #(
  parameter int N_ENT   = 8,
  parameter int IDX_W   = 3,
  parameter int ALLOC_W = 2,
  parameter int ISSUE_W = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [ALLOC_W-1:0]         alloc_req,
  output logic [ALLOC_W-1:0]         alloc_gnt,
  output logic [ALLOC_W*IDX_W-1:0]   alloc_idx,
  output logic                       rs_full,
  input  logic [N_ENT-1:0]           rdy_in,
  input  logic                       issue_stall,
  output logic [ISSUE_W-1:0]         issue_vld,
  output logic [ISSUE_W*IDX_W-1:0]   issue_idx,
  output logic [N_ENT-1:0]           busy
`ifdef RS_OCC_STATS_EN
  ,
  output logic [IDX_W:0]             occ_cnt,
  output logic [IDX_W:0]             occ_peak
`endif
);

  localparam int CNT_W = IDX_W + 1;

  logic [N_ENT-1:0]             busy_q;
  logic [N_ENT-1:0]             busy_d;
  logic [N_ENT-1:0][N_ENT-1:0]  older_q;
  logic [N_ENT-1:0][N_ENT-1:0]  older_d;
  logic [N_ENT-1:0]             alloc_mask;
  logic [N_ENT-1:0]             sel_mask;
  logic [N_ENT-1:0]             issued_mask;
  logic [N_ENT-1:0]             survivors;
  logic [N_ENT-1:0]             remaining;
  logic [N_ENT-1:0]             prior;
  logic [CNT_W-1:0]             free_cnt;
  logic [IDX_W-1:0]             kth_free [ALLOC_W];
  logic                         chain;
  logic                         found;
  logic                         is_oldest;
  logic [ISSUE_W-1:0]           sel_vld;
  logic [ISSUE_W*IDX_W-1:0]     sel_idx;

  assign busy = busy_q;

  // Find the k lowest free slots and grant ports in order; a failed port blocks all higher ports
  always_comb begin
    free_cnt   = '0;
    alloc_gnt  = '0;
    alloc_idx  = '0;
    alloc_mask = '0;
    chain      = 1'b1;
    for (int k = 0; k < ALLOC_W; k++) begin
      kth_free[k] = '0;
    end
    for (int i = 0; i < N_ENT; i++) begin
      if (!busy_q[i]) begin
        for (int k = 0; k < ALLOC_W; k++) begin
          if (free_cnt == CNT_W'(k)) begin
            kth_free[k] = IDX_W'(i);
          end
        end
        free_cnt = free_cnt + CNT_W'(1);
      end
    end
    for (int k = 0; k < ALLOC_W; k++) begin
      alloc_gnt[k] = chain && alloc_req[k] && !flush && (free_cnt > CNT_W'(k));
      chain        = alloc_gnt[k];
      if (alloc_gnt[k]) begin
        alloc_idx[k*IDX_W +: IDX_W] = kth_free[k];
        for (int i = 0; i < N_ENT; i++) begin
          if (kth_free[k] == IDX_W'(i)) begin
            alloc_mask[i] = 1'b1;
          end
        end
      end
    end
  end

  // Full whenever fewer slots are free than one cycle's worth of allocation ports
  always_comb begin
    rs_full = (free_cnt < CNT_W'(ALLOC_W));
  end

  // Pick the oldest ready entry per issue port, removing each winner before the next port looks
  always_comb begin
    remaining = busy_q & rdy_in;
    sel_mask  = '0;
    sel_vld   = '0;
    sel_idx   = '0;
    found     = 1'b0;
    is_oldest = 1'b0;
    for (int p = 0; p < ISSUE_W; p++) begin
      found = 1'b0;
      for (int i = 0; i < N_ENT; i++) begin
        if (!found && remaining[i]) begin
          is_oldest = 1'b1;
          for (int j = 0; j < N_ENT; j++) begin
            if (j != i && remaining[j] && older_q[j][i]) begin
              is_oldest = 1'b0;
            end
          end
          if (is_oldest) begin
            found                       = 1'b1;
            sel_vld[p]                  = 1'b1;
            sel_idx[p*IDX_W +: IDX_W]   = IDX_W'(i);
            sel_mask[i]                 = 1'b1;
          end
        end
      end
      remaining = remaining & ~sel_mask;
    end
  end

  // Next occupancy and age: a new entry is younger than every survivor and every lower-port grant
  always_comb begin
    issued_mask = issue_stall ? '0 : sel_mask;
    survivors   = busy_q & ~issued_mask;
    busy_d      = survivors | alloc_mask;
    older_d     = older_q;
    prior       = '0;
    for (int k = 0; k < ALLOC_W; k++) begin
      for (int i = 0; i < N_ENT; i++) begin
        if (alloc_gnt[k] && kth_free[k] == IDX_W'(i)) begin
          older_d[i] = '0;
          for (int j = 0; j < N_ENT; j++) begin
            older_d[j][i] = survivors[j] | prior[j];
          end
          prior[i] = 1'b1;
        end
      end
    end
  end

  // State and issue registers; flush clears everything ahead of allocation and issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q    <= '0;
      older_q   <= '0;
      issue_vld <= '0;
      issue_idx <= '0;
    end else if (flush) begin
      busy_q    <= '0;
      older_q   <= '0;
      issue_vld <= '0;
      issue_idx <= '0;
    end else begin
      busy_q  <= busy_d;
      older_q <= older_d;
      if (issue_stall) begin
        issue_vld <= '0;
        issue_idx <= '0;
      end else begin
        issue_vld <= sel_vld;
        issue_idx <= sel_idx;
      end
    end
  end

`ifdef RS_OCC_STATS_EN
  logic [CNT_W-1:0] occ_d;

  // Population count of the occupancy that will be registered at the next edge
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < N_ENT; i++) begin
      if (busy_d[i]) begin
        occ_d = occ_d + CNT_W'(1);
      end
    end
  end

  // Occupancy count tracks busy; peak holds the high-water mark since reset or flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_cnt  <= '0;
      occ_peak <= '0;
    end else if (flush) begin
      occ_cnt  <= '0;
      occ_peak <= '0;
    end else begin
      occ_cnt  <= occ_d;
      occ_peak <= (occ_d > occ_peak) ? occ_d : occ_peak;
    end
  end
`endif

endmodule

// File: tb/tb_rs_alloc_issue_ctrl.sv
// Testbench for rs_alloc_issue_ctrl (default parameters: 8 entries, 2 alloc, 2 issue).
// Issue outputs are checked by a scoreboard monitor; allocation/busy by direct checks.
module tb_rs_alloc_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [1:0] alloc_req = '0;
  logic [1:0] alloc_gnt;
  logic [5:0] alloc_idx;
  logic       rs_full;
  logic [7:0] rdy_in = '0;
  logic       issue_stall = 1'b0;
  logic [1:0] issue_vld;
  logic [5:0] issue_idx;
  logic [7:0] busy;
`ifdef RS_OCC_STATS_EN
  logic [3:0] occ_cnt;
  logic [3:0] occ_peak;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [1:0] vld;
    logic [5:0] idx;
  } exp_t;

  exp_t exp_q[$];

  rs_alloc_issue_ctrl #(
    .N_ENT(8), .IDX_W(3), .ALLOC_W(2), .ISSUE_W(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .alloc_req(alloc_req),
    .alloc_gnt(alloc_gnt),
    .alloc_idx(alloc_idx),
    .rs_full(rs_full),
    .rdy_in(rdy_in),
    .issue_stall(issue_stall),
    .issue_vld(issue_vld),
    .issue_idx(issue_idx),
    .busy(busy)
`ifdef RS_OCC_STATS_EN
    ,
    .occ_cnt(occ_cnt),
    .occ_peak(occ_peak)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] req, input logic [7:0] rdy,
                               input logic stall, input logic flsh);
    alloc_req   = req;
    rdy_in      = rdy;
    issue_stall = stall;
    flush       = flsh;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expectIssue(input logic [1:0] vld, input logic [5:0] idx);
    exp_t e;
    e.vld = vld;
    e.idx = idx;
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle the DUT presents an issue, pop the expected record and compare
  always @(negedge clk) begin
    if (!rst && issue_vld != 2'b00) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL issue_unexpected: got vld=%b idx=0x%0h, expected no issue at %0t",
                 issue_vld, issue_idx, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("issue_vld", 32'(issue_vld), 32'(e.vld));
        checkOutput("issue_idx", 32'(issue_idx), 32'(e.idx));
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("rst_busy", 32'(busy), 32'h00);
    checkOutput("rst_vld", 32'(issue_vld), 32'h0);
    checkOutput("rst_idx", 32'(issue_idx), 32'h0);
    checkOutput("rst_full", 32'(rs_full), 32'h0);
`ifdef RS_OCC_STATS_EN
    checkOutput("rst_occ", 32'(occ_cnt), 32'h0);
    checkOutput("rst_peak", 32'(occ_peak), 32'h0);
`endif

    // Dual allocation into an empty RS, then fill
    applyStimulus(2'b11, 8'h00, 1'b0, 1'b0);
    checkOutput("alloc_gnt_first", 32'(alloc_gnt), 32'h3);
    checkOutput("alloc_idx_first", 32'(alloc_idx), 32'h08);
    tick();
    checkOutput("busy_after_first", 32'(busy), 32'h03);
    checkOutput("alloc_idx_second", 32'(alloc_idx), 32'h1A);
    repeat (3) tick();
    checkOutput("busy_full", 32'(busy), 32'hFF);
    checkOutput("full_flag", 32'(rs_full), 32'h1);
    checkOutput("full_gnt", 32'(alloc_gnt), 32'h0);

    // Partial grant with only entry 0 free
    applyStimulus(2'b00, 8'h01, 1'b0, 1'b0);
    expectIssue(2'b01, 6'h00);
    tick();
    checkOutput("busy_fe", 32'(busy), 32'hFE);
    applyStimulus(2'b11, 8'h00, 1'b0, 1'b0);
    checkOutput("partial_gnt", 32'(alloc_gnt), 32'h1);
    checkOutput("partial_idx", 32'(alloc_idx), 32'h00);
    checkOutput("partial_full", 32'(rs_full), 32'h1);

    // Flush beats allocation
    applyStimulus(2'b01, 8'h00, 1'b0, 1'b1);
    checkOutput("flush_gnt", 32'(alloc_gnt), 32'h0);
    tick();
    checkOutput("flush_busy", 32'(busy), 32'h00);
    checkOutput("flush_vld", 32'(issue_vld), 32'h0);

    // Oldest-first: re-allocate 5, then 2, then 7 into a full RS
    applyStimulus(2'b11, 8'h00, 1'b0, 1'b0);
    repeat (4) tick();
    checkOutput("refill_busy", 32'(busy), 32'hFF);
    applyStimulus(2'b00, 8'h20, 1'b0, 1'b0);
    expectIssue(2'b01, 6'h05);
    tick();
    checkOutput("busy_df", 32'(busy), 32'hDF);
    applyStimulus(2'b01, 8'h00, 1'b0, 1'b0);
    checkOutput("realloc5_idx", 32'(alloc_idx), 32'h05);
    tick();
    applyStimulus(2'b00, 8'h04, 1'b0, 1'b0);
    expectIssue(2'b01, 6'h02);
    tick();
    checkOutput("busy_fb", 32'(busy), 32'hFB);
    applyStimulus(2'b01, 8'h00, 1'b0, 1'b0);
    checkOutput("realloc2_idx", 32'(alloc_idx), 32'h02);
    tick();
    applyStimulus(2'b00, 8'h80, 1'b0, 1'b0);
    expectIssue(2'b01, 6'h07);
    tick();
    checkOutput("busy_7f", 32'(busy), 32'h7F);
    applyStimulus(2'b01, 8'h00, 1'b0, 1'b0);
    checkOutput("realloc7_idx", 32'(alloc_idx), 32'h07);
    tick();
    checkOutput("busy_ff_again", 32'(busy), 32'hFF);
    applyStimulus(2'b00, 8'hA4, 1'b0, 1'b0);
    expectIssue(2'b11, {3'd2, 3'd5});
    tick();
    checkOutput("busy_db", 32'(busy), 32'hDB);
    expectIssue(2'b01, {3'd0, 3'd7});
    tick();
    checkOutput("busy_5b", 32'(busy), 32'h5B);

    // Stall holds everything for three cycles, then the two oldest go
    applyStimulus(2'b00, 8'hFF, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("stall_busy", 32'(busy), 32'h5B);
      checkOutput("stall_vld", 32'(issue_vld), 32'h0);
    end
    applyStimulus(2'b00, 8'hFF, 1'b0, 1'b0);
    expectIssue(2'b11, {3'd1, 3'd0});
    tick();
    checkOutput("busy_58", 32'(busy), 32'h58);
    applyStimulus(2'b00, 8'h00, 1'b0, 1'b0);

    // Same-cycle alloc and issue: a slot freed by issue is reusable only next cycle
    applyStimulus(2'b00, 8'h00, 1'b0, 1'b1);
    tick();
    applyStimulus(2'b11, 8'h00, 1'b0, 1'b0);
    repeat (4) tick();
    checkOutput("fill3_busy", 32'(busy), 32'hFF);
    applyStimulus(2'b01, 8'h01, 1'b0, 1'b0);
    checkOutput("same_cycle_gnt", 32'(alloc_gnt), 32'h0);
    expectIssue(2'b01, 6'h00);
    tick();
    checkOutput("same_cycle_busy", 32'(busy), 32'hFE);
    applyStimulus(2'b01, 8'h00, 1'b0, 1'b0);
    checkOutput("next_cycle_gnt", 32'(alloc_gnt), 32'h1);
    checkOutput("next_cycle_idx", 32'(alloc_idx), 32'h00);
    tick();
    checkOutput("busy_ff_third", 32'(busy), 32'hFF);
    applyStimulus(2'b00, 8'h03, 1'b0, 1'b0);
    expectIssue(2'b11, {3'd0, 3'd1});
    tick();
    checkOutput("busy_fc", 32'(busy), 32'hFC);
`ifdef RS_OCC_STATS_EN
    checkOutput("occ_fc", 32'(occ_cnt), 32'h6);
    checkOutput("peak_fill", 32'(occ_peak), 32'h8);
`endif

    // Mid-operation flush with every entry ready
    applyStimulus(2'b00, 8'hFF, 1'b0, 1'b1);
    tick();
    checkOutput("midflush_busy", 32'(busy), 32'h00);
    checkOutput("midflush_vld", 32'(issue_vld), 32'h0);
`ifdef RS_OCC_STATS_EN
    checkOutput("flush_occ", 32'(occ_cnt), 32'h0);
    checkOutput("flush_peak", 32'(occ_peak), 32'h0);
`endif

    // Asynchronous reset between edges clears registered outputs at once
    applyStimulus(2'b11, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("pre_rst_busy", 32'(busy), 32'h03);
    applyStimulus(2'b00, 8'h01, 1'b0, 1'b0);
    expectIssue(2'b01, 6'h00);
    tick();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("async_busy", 32'(busy), 32'h00);
    checkOutput("async_vld", 32'(issue_vld), 32'h0);
    checkOutput("async_idx", 32'(issue_idx), 32'h0);
    applyStimulus(2'b00, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (2) tick();

    checkOutput("sb_drain", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
